arc_seq_ctrl: RTL and testbench
===============================

# arc_seq_ctrl

Segment sequencer for the point-by-point circular interpolator. It buffers arc segments (start point, end point, direction) from the host or path planner in a small FIFO. It hands each segment to the interpolator with a one-cycle load strobe and waits for the interpolator's done pulse. It also tracks the live tool position from the step pulses, guards against non-terminating arcs with a watchdog, and sits between the command front end and the interpolator / stepper drivers.

## Interface
- DEPTH, 4: segment FIFO entries (power of 2, ≥2)
- CW, 16: signed coordinate width
- TO_W, 20: watchdog counter width
- pulse_clk  in  1  interpolation clock, shared with interpolator
- sys_rst_l  in  1  reset, asynchronous, active-low
- seg_valid  in  1  segment offered
- seg_ready  out  1  FIFO can accept
- seg_xs, seg_ys, seg_xe, seg_ye  in  CW each, signed  start/end coordinates
- seg_dir  in  1  1 = clockwise (SR), 0 = counter-clockwise (NR)
- run_en  in  1  level; permits launching segments
- abort  in  1  pulse; flush queue, stop after current arc
- clear_err  in  1  pulse; leave ERR
- ip_xs, ip_ys, ip_xe, ip_ye  out  CW each  to interpolator
- ip_dir  out  1  to interpolator
- ip_change_readyH  out  1  load strobe
- ip_draw_overH  in  1  interpolator done pulse
- ip_x_acc, ip_x_dec, ip_y_acc, ip_y_dec  in  1 each  step pulses
- pos_x, pos_y  out  CW  tracked position
- busy  out  1  not in IDLE
- seg_done  out  1  one-cycle pulse per finished arc
- fifo_cnt  out  log2(DEPTH)+1  occupancy
- err_timeout  out  1  sticky watchdog error
- err_pos  out  1  sticky endpoint mismatch (see Configuration)

## Operation
- FIFO push when seg_valid && seg_ready. seg_ready = (fifo_cnt < DEPTH) && !abort && state != ERR. A pop in the same cycle does not open a slot in a full FIFO.
- FSM states: IDLE, LOAD, RUN, DRAIN, ERR.
- IDLE → LOAD when run_en && fifo_cnt != 0. On that edge the FIFO head is popped into the ip_* holding registers, and pos_x/pos_y are loaded with the head's seg_xs/seg_ys.
- LOAD: ip_change_readyH = 1 for exactly one cycle. Next state is RUN.
- RUN: each ip_x_acc/ip_x_dec/ip_y_acc/ip_y_dec adds +1/−1 to pos. When acc and dec arrive on the same axis in the same cycle, pos is unchanged. The watchdog counts every RUN cycle and clears on LOAD.
  - ip_draw_overH → seg_done pulse, then IDLE. The next LOAD follows after one or more IDLE cycles, which guarantees the interpolator is back in its idle state.
  - abort → DRAIN. The FIFO is flushed on the same edge.
  - Watchdog reaches all-ones → ERR. err_timeout is set and the FIFO is flushed.
- DRAIN: behaves like RUN (tracking, watchdog), but ip_draw_overH → IDLE with seg_done pulsed. New segments are refused while in DRAIN.
- abort in IDLE or LOAD: the FIFO is flushed. LOAD still completes and enters DRAIN, because the interpolator has already latched the segment.
- ERR: outputs hold and step pulses are ignored. clear_err → IDLE with err flags cleared. The system must reset the interpolator before clearing.
- ip_* outputs stay stable from LOAD until the next LOAD.
- Arithmetic: pos wraps modulo 2^CW with no saturation. The watchdog saturates into ERR.

## Timing
- Reset values: all outputs 0; state IDLE; FIFO empty; seg_ready 1 (DEPTH > 0).
- Push at edge N into an empty FIFO with run_en high: fifo_cnt = 1 after N, ip_change_readyH high during cycle N+1…N+2, RUN from N+2.
- ip_draw_overH sampled at edge M: seg_done high during M…M+1, IDLE from M. The earliest next ip_change_readyH is from edge M+1.
- All outputs are registered. There is no combinational path from ip_* inputs to outputs except seg_ready, which is a function of registered count/state plus abort.
- Reset asserted mid-arc: everything returns to reset values immediately. The queue is lost.

## Configuration
- ARC_SEQ_POS_CHECK_EN defined: when ip_draw_overH is sampled, (pos_x, pos_y), including any step pulse in that same cycle, is compared to (ip_xe, ip_ye). A mismatch sets err_pos. err_pos is sticky until clear_err or reset and does not stop sequencing.
- ARC_SEQ_POS_CHECK_EN undefined: comparator removed and err_pos tied 0. Position tracking remains.

## Structure
- Package arc_pkg: FSM state encoding; a segment record type (xs, ys, xe, ye, dir; 4·CW+1 bits); CW default constant.
- Sub-module arc_seg_fifo: synchronous DEPTH-entry FIFO holding the segment record, with push/pop/flush and count. Same clock and reset as the top.

## Test plan
- Single arc (0,5)→(5,0), dir=1, run_en=1: one change_readyH pulse; pos_x/pos_y walk to (5,0) with 10 step pulses total; seg_done once; err_pos 0.
- Fill 4 segments with run_en=0: seg_ready drops after the 4th push; a 5th offer is not accepted; fifo_cnt=4. Raising run_en gives four back-to-back arcs, each with an IDLE gap ≥1 cycle.
- Abort during the 2nd of 3 queued arcs: FIFO count goes to 0 at the abort edge; the 2nd arc completes with seg_done; the 3rd never loads; FSM returns to IDLE.
- Interpolator model never asserts ip_draw_overH, TO_W=6: err_timeout is set 63 cycles after RUN entry; state ERR; clear_err returns to IDLE.
- With ARC_SEQ_POS_CHECK_EN: the model emits one fewer y step before done → err_pos=1. Without the macro, err_pos stays 0.
- sys_rst_l low mid-RUN: all outputs 0 asynchronously; after release, the FIFO is empty and seg_ready=1.

Source files
------------

// File: rtl/arc_pkg.sv
// Shared types for the arc segment sequencer: FSM encoding and the segment record.
package arc_pkg;

    localparam int CW_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ERR   = 3'd4
    } arc_state_t;

    // Default-width segment record; the FIFO stores the same field order flattened.
    typedef struct packed {
        logic [CW_DEF-1:0] xs;
        logic [CW_DEF-1:0] ys;
        logic [CW_DEF-1:0] xe;
        logic [CW_DEF-1:0] ye;
        logic              dir;
    } arc_seg_t;

    function automatic int seg_w(input int cw);
        return 4 * cw + 1;
    endfunction

endpackage

// File: rtl/arc_seq_ctrl_fifo.sv
// Synchronous segment FIFO with push/pop/flush and occupancy count (module arc_seg_fifo).
module arc_seg_fifo #(
    parameter int  DEPTH = 4,
    parameter int  W     = 65,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [AW:0]   cnt
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Full check uses the registered count, so a same-cycle pop never frees a slot.
    assign do_push = push && (cnt < FULL);
    assign do_pop  = pop && (cnt != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/arc_seq_ctrl.sv
// Arc segment sequencer: queues segments, strobes them into the interpolator, tracks position.
// Optional endpoint check enabled by defining ARC_SEQ_POS_CHECK_EN.
//
// state    | meaning
// IDLE     | waiting for run_en and a queued segment
// LOAD     | ip_change_readyH strobe, watchdog reload
// RUN      | arc in progress, tracking steps
// DRAIN    | aborted: finish current arc, queue flushed and closed
// ERR      | watchdog expired, frozen until clear_err
module arc_seq_ctrl
    import arc_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  CW    = CW_DEF,
    parameter int  TO_W  = 20,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          pulse_clk,
    input  logic          sys_rst_l,
    input  logic          seg_valid,
    output logic          seg_ready,
    input  logic [CW-1:0] seg_xs,
    input  logic [CW-1:0] seg_ys,
    input  logic [CW-1:0] seg_xe,
    input  logic [CW-1:0] seg_ye,
    input  logic          seg_dir,
    input  logic          run_en,
    input  logic          abort,
    input  logic          clear_err,
    output logic [CW-1:0] ip_xs,
    output logic [CW-1:0] ip_ys,
    output logic [CW-1:0] ip_xe,
    output logic [CW-1:0] ip_ye,
    output logic          ip_dir,
    output logic          ip_change_readyH,
    input  logic          ip_draw_overH,
    input  logic          ip_x_acc,
    input  logic          ip_x_dec,
    input  logic          ip_y_acc,
    input  logic          ip_y_dec,
    output logic [CW-1:0] pos_x,
    output logic [CW-1:0] pos_y,
    output logic          busy,
    output logic          seg_done,
    output logic [AW:0]   fifo_cnt,
    output logic          err_timeout,
    output logic          err_pos
);

    localparam int          SW   = seg_w(CW);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    arc_state_t    state;
    logic [TO_W-1:0] wd;
    logic [SW-1:0] head;
    logic [CW-1:0] h_xs, h_ys, h_xe, h_ye;
    logic          h_dir;
    logic [CW-1:0] nx_x, nx_y;
    logic          tracking;
    logic          launch;
    logic          to_hit;
    logic          flush;
    logic          push;

    assign {h_xs, h_ys, h_xe, h_ye, h_dir} = head;

    assign tracking  = (state == ST_RUN) || (state == ST_DRAIN);
    assign launch    = (state == ST_IDLE) && run_en && (fifo_cnt != '0) && !abort;
    // Watchdog is a down-counter reloaded on LOAD; expiry is the step that would reach zero.
    assign to_hit    = tracking && !ip_draw_overH && (wd == TO_W'(1));
    assign flush     = abort || to_hit;
    assign seg_ready = (fifo_cnt < FULL) && !abort && (state != ST_ERR) && (state != ST_DRAIN);
    assign push      = seg_valid && seg_ready;

    // acc alone gives +1, dec alone gives -1, both cancel.
    assign nx_x = pos_x + {{(CW-1){ip_x_dec & ~ip_x_acc}}, ip_x_acc ^ ip_x_dec};
    assign nx_y = pos_y + {{(CW-1){ip_y_dec & ~ip_y_acc}}, ip_y_acc ^ ip_y_dec};

    arc_seg_fifo #(.DEPTH(DEPTH), .W(SW)) u_fifo (
        .clk   (pulse_clk),
        .rst_n (sys_rst_l),
        .push  (push),
        .pop   (launch),
        .flush (flush),
        .din   ({seg_xs, seg_ys, seg_xe, seg_ye, seg_dir}),
        .head  (head),
        .cnt   (fifo_cnt)
    );

    always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state            <= ST_IDLE;
            wd               <= '0;
            ip_xs            <= '0;
            ip_ys            <= '0;
            ip_xe            <= '0;
            ip_ye            <= '0;
            ip_dir           <= 1'b0;
            ip_change_readyH <= 1'b0;
            pos_x            <= '0;
            pos_y            <= '0;
            busy             <= 1'b0;
            seg_done         <= 1'b0;
            err_timeout      <= 1'b0;
            err_pos          <= 1'b0;
        end else begin
            ip_change_readyH <= 1'b0;
            seg_done         <= 1'b0;
            if (clear_err) err_pos <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state            <= ST_LOAD;
                        ip_xs            <= h_xs;
                        ip_ys            <= h_ys;
                        ip_xe            <= h_xe;
                        ip_ye            <= h_ye;
                        ip_dir           <= h_dir;
                        pos_x            <= h_xs;
                        pos_y            <= h_ys;
                        ip_change_readyH <= 1'b1;
                        busy             <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    wd    <= '1;
                    state <= abort ? ST_DRAIN : ST_RUN;
                end
                ST_RUN, ST_DRAIN: begin
                    pos_x <= nx_x;
                    pos_y <= nx_y;
                    if (ip_draw_overH) begin
                        state    <= ST_IDLE;
                        seg_done <= 1'b1;
                        busy     <= 1'b0;
`ifdef ARC_SEQ_POS_CHECK_EN
                        if ((nx_x != ip_xe) || (nx_y != ip_ye)) err_pos <= 1'b1;
`endif
                    end else if (to_hit) begin
                        state       <= ST_ERR;
                        wd          <= wd - 1'b1;
                        err_timeout <= 1'b1;
                    end else begin
                        wd <= wd - 1'b1;
                        if ((state == ST_RUN) && abort) state <= ST_DRAIN;
                    end
                end
                ST_ERR: begin
                    if (clear_err) begin
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                        err_timeout <= 1'b0;
                        err_pos     <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arc_seq_ctrl.sv
// Directed bench for arc_seq_ctrl with hand-computed expectations (TO_W=6 for the watchdog case).
module tb_arc_seq_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = 16;
    localparam int TO_W  = 6;

`ifdef ARC_SEQ_POS_CHECK_EN
    localparam logic POSCHK = 1'b1;
`else
    localparam logic POSCHK = 1'b0;
`endif

    logic          pulse_clk = 1'b0;
    logic          sys_rst_l;
    logic          seg_valid, seg_ready;
    logic [CW-1:0] seg_xs, seg_ys, seg_xe, seg_ye;
    logic          seg_dir, run_en, abort, clear_err;
    logic [CW-1:0] ip_xs, ip_ys, ip_xe, ip_ye;
    logic          ip_dir, ip_change_readyH, ip_draw_overH;
    logic          ip_x_acc, ip_x_dec, ip_y_acc, ip_y_dec;
    logic [CW-1:0] pos_x, pos_y;
    logic          busy, seg_done, err_timeout, err_pos;
    logic [2:0]    fifo_cnt;

    int tests = 0;
    int fails = 0;
    int loads = 0;
    int dones = 0;

    always #5 pulse_clk = ~pulse_clk;

    arc_seq_ctrl #(.DEPTH(DEPTH), .CW(CW), .TO_W(TO_W)) dut (
        .pulse_clk        (pulse_clk),
        .sys_rst_l        (sys_rst_l),
        .seg_valid        (seg_valid),
        .seg_ready        (seg_ready),
        .seg_xs           (seg_xs),
        .seg_ys           (seg_ys),
        .seg_xe           (seg_xe),
        .seg_ye           (seg_ye),
        .seg_dir          (seg_dir),
        .run_en           (run_en),
        .abort            (abort),
        .clear_err        (clear_err),
        .ip_xs            (ip_xs),
        .ip_ys            (ip_ys),
        .ip_xe            (ip_xe),
        .ip_ye            (ip_ye),
        .ip_dir           (ip_dir),
        .ip_change_readyH (ip_change_readyH),
        .ip_draw_overH    (ip_draw_overH),
        .ip_x_acc         (ip_x_acc),
        .ip_x_dec         (ip_x_dec),
        .ip_y_acc         (ip_y_acc),
        .ip_y_dec         (ip_y_dec),
        .pos_x            (pos_x),
        .pos_y            (pos_y),
        .busy             (busy),
        .seg_done         (seg_done),
        .fifo_cnt         (fifo_cnt),
        .err_timeout      (err_timeout),
        .err_pos          (err_pos)
    );

    // One-cycle pulses are seen at exactly one falling edge each.
    always @(negedge pulse_clk) begin
        if (ip_change_readyH === 1'b1) loads++;
        if (seg_done === 1'b1) dones++;
    end

    task automatic tick();
        @(posedge pulse_clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        tests++;
        assert (obs == exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_seg(input logic [15:0] xs, input logic [15:0] ys,
                            input logic [15:0] xe, input logic [15:0] ye, input logic dir);
        seg_xs = xs; seg_ys = ys; seg_xe = xe; seg_ye = ye; seg_dir = dir;
        seg_valid = 1'b1;
        tick();
        seg_valid = 1'b0;
    endtask

    task automatic wait_load(input string tag);
        int n = 0;
        while (ip_change_readyH !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk1(tag, ip_change_readyH, 1'b1);
    endtask

    task automatic step(input logic xa, input logic xd, input logic ya, input logic yd);
        ip_x_acc = xa; ip_x_dec = xd; ip_y_acc = ya; ip_y_dec = yd;
        tick();
        ip_x_acc = 1'b0; ip_x_dec = 1'b0; ip_y_acc = 1'b0; ip_y_dec = 1'b0;
    endtask

    task automatic done_pulse();
        ip_draw_overH = 1'b1;
        tick();
        ip_draw_overH = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        sys_rst_l = 1'b0;
        seg_valid = 1'b0; seg_xs = '0; seg_ys = '0; seg_xe = '0; seg_ye = '0; seg_dir = 1'b0;
        run_en = 1'b0; abort = 1'b0; clear_err = 1'b0;
        ip_draw_overH = 1'b0;
        ip_x_acc = 1'b0; ip_x_dec = 1'b0; ip_y_acc = 1'b0; ip_y_dec = 1'b0;

        // Reset values
        #12;
        chk16("rst_pos_x", pos_x, 16'd0);
        chk1("rst_busy", busy, 1'b0);
        chk16("rst_cnt", 16'(fifo_cnt), 16'd0);
        chk1("rst_chg", ip_change_readyH, 1'b0);
        chk1("rst_ready", seg_ready, 1'b1);
        chk1("rst_err_to", err_timeout, 1'b0);
        chk16("rst_ip_xs", ip_xs, 16'd0);
        sys_rst_l = 1'b1;
        tick();

        // Single arc (0,5)->(5,0) clockwise
        run_en = 1'b1;
        push_seg(16'd0, 16'd5, 16'd5, 16'd0, 1'b1);
        chk16("t1_cnt_after_push", 16'(fifo_cnt), 16'd1);
        tick();
        chk1("t1_chg_high", ip_change_readyH, 1'b1);
        chk16("t1_pos_x_load", pos_x, 16'd0);
        chk16("t1_pos_y_load", pos_y, 16'd5);
        chk16("t1_ip_xe", ip_xe, 16'd5);
        chk16("t1_ip_ye", ip_ye, 16'd0);
        chk1("t1_ip_dir", ip_dir, 1'b1);
        chk16("t1_cnt_popped", 16'(fifo_cnt), 16'd0);
        chk1("t1_busy", busy, 1'b1);
        tick();
        chk1("t1_chg_low", ip_change_readyH, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk16("t1_pos_x_mid", pos_x, 16'd2);
        chk16("t1_pos_y_mid", pos_y, 16'd3);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk16("t1_pos_x_end", pos_x, 16'd5);
        chk16("t1_pos_y_end", pos_y, 16'd0);
        done_pulse();
        chk1("t1_seg_done", seg_done, 1'b1);
        chk1("t1_idle", busy, 1'b0);
        chk1("t1_err_pos", err_pos, 1'b0);
        tick();
        chk1("t1_seg_done_low", seg_done, 1'b0);
        chki("t1_loads", loads, 1);
        chki("t1_dones", dones, 1);

        // Fill the queue with run_en low, then drain four back-to-back arcs
        run_en = 1'b0;
        push_seg(16'd10, 16'd20, 16'd10, 16'd20, 1'b0);
        push_seg(16'd11, 16'd21, 16'd11, 16'd21, 1'b1);
        push_seg(16'd12, 16'd22, 16'd12, 16'd22, 1'b0);
        push_seg(16'd13, 16'd23, 16'd13, 16'd23, 1'b1);
        chk16("t2_cnt_full", 16'(fifo_cnt), 16'd4);
        chk1("t2_ready_full", seg_ready, 1'b0);
        push_seg(16'd99, 16'd99, 16'd99, 16'd99, 1'b0);
        chk16("t2_cnt_5th", 16'(fifo_cnt), 16'd4);
        run_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_load("t2_load");
            chk16("t2_ip_xs", ip_xs, 16'(10 + i));
            chk16("t2_ip_ys", ip_ys, 16'(20 + i));
            chk1("t2_ip_dir", ip_dir, i[0]);
            tick();
            if (i == 0) begin
                step(1'b1, 1'b1, 1'b1, 1'b1);
                chk16("t2_cancel_x", pos_x, 16'd10);
                chk16("t2_cancel_y", pos_y, 16'd20);
            end
            done_pulse();
            chk1("t2_seg_done", seg_done, 1'b1);
            chk1("t2_idle_gap", busy, 1'b0);
            chk1("t2_no_chg_in_gap", ip_change_readyH, 1'b0);
        end
        tick();
        chk16("t2_cnt_empty", 16'(fifo_cnt), 16'd0);
        chki("t2_loads", loads, 5);
        chki("t2_dones", dones, 5);

        // Abort during the second of three queued arcs
        run_en = 1'b0;
        push_seg(16'd20, 16'd0, 16'd20, 16'd0, 1'b0);
        push_seg(16'd21, 16'd0, 16'd21, 16'd0, 1'b0);
        push_seg(16'd22, 16'd0, 16'd22, 16'd0, 1'b0);
        run_en = 1'b1;
        wait_load("t3_load1");
        chk16("t3_ip_xs1", ip_xs, 16'd20);
        tick();
        done_pulse();
        wait_load("t3_load2");
        chk16("t3_ip_xs2", ip_xs, 16'd21);
        tick();
        chk16("t3_cnt_before", 16'(fifo_cnt), 16'd1);
        abort = 1'b1;
        #1;
        chk1("t3_ready_abort", seg_ready, 1'b0);
        tick();
        abort = 1'b0;
        chk16("t3_cnt_flushed", 16'(fifo_cnt), 16'd0);
        chk1("t3_busy_drain", busy, 1'b1);
        chk1("t3_ready_drain", seg_ready, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk16("t3_drain_track", pos_x, 16'd22);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk16("t3_drain_back", pos_x, 16'd21);
        done_pulse();
        chk1("t3_seg_done", seg_done, 1'b1);
        chk1("t3_idle", busy, 1'b0);
        repeat (6) tick();
        chki("t3_no_third_load", loads, 7);
        chki("t3_dones", dones, 7);
        chk1("t3_still_idle", busy, 1'b0);

        // Watchdog: interpolator never finishes
        push_seg(16'd0, 16'd0, 16'd9, 16'd9, 1'b0);
        wait_load("t4_load");
        repeat (63) tick();
        chk1("t4_not_yet", err_timeout, 1'b0);
        chk1("t4_busy_run", busy, 1'b1);
        tick();
        chk1("t4_err_timeout", err_timeout, 1'b1);
        chk1("t4_ready_err", seg_ready, 1'b0);
        chk1("t4_busy_err", busy, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk16("t4_steps_ignored", pos_x, 16'd0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk1("t4_cleared", err_timeout, 1'b0);
        chk1("t4_idle", busy, 1'b0);
        chk1("t4_ready", seg_ready, 1'b1);

        // Endpoint check: one y step short, then a wrapping arc with steps in the done cycle
        push_seg(16'd0, 16'd0, 16'd2, 16'd2, 1'b0);
        wait_load("t5_load1");
        tick();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        ip_x_acc = 1'b1;
        done_pulse();
        ip_x_acc = 1'b0;
        chk1("t5_seg_done", seg_done, 1'b1);
        chk16("t5_pos_x", pos_x, 16'd2);
        chk16("t5_pos_y", pos_y, 16'd1);
        chk1("t5_err_pos", err_pos, POSCHK);
        push_seg(16'h7fff, 16'd3, 16'h8000, 16'd4, 1'b1);
        wait_load("t5_load2");
        tick();
        ip_x_acc = 1'b1; ip_y_acc = 1'b1;
        done_pulse();
        ip_x_acc = 1'b0; ip_y_acc = 1'b0;
        chk16("t5_wrap_x", pos_x, 16'h8000);
        chk16("t5_wrap_y", pos_y, 16'd4);
        chk1("t5_err_sticky", err_pos, POSCHK);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk1("t5_err_cleared", err_pos, 1'b0);

        // Asynchronous reset in the middle of an arc
        run_en = 1'b0;
        push_seg(16'd1, 16'd7, 16'd1, 16'd7, 1'b1);
        push_seg(16'd2, 16'd8, 16'd2, 16'd8, 1'b1);
        run_en = 1'b1;
        wait_load("t6_load");
        tick();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk16("t6_cnt_before", 16'(fifo_cnt), 16'd1);
        chk16("t6_pos_before", pos_x, 16'd2);
        #2;
        sys_rst_l = 1'b0;
        #1;
        chk1("t6_busy", busy, 1'b0);
        chk16("t6_pos_x", pos_x, 16'd0);
        chk16("t6_cnt", 16'(fifo_cnt), 16'd0);
        chk16("t6_ip_ys", ip_ys, 16'd0);
        chk1("t6_ip_dir", ip_dir, 1'b0);
        run_en = 1'b0;
        #3;
        sys_rst_l = 1'b1;
        tick();
        chk16("t6_cnt_after", 16'(fifo_cnt), 16'd0);
        chk1("t6_ready_after", seg_ready, 1'b1);
        chk1("t6_busy_after", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
